// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit for the 5-stage pipeline: computes bypass selects
// in ID, registers them into EX, and detects load-use and MDU RAW/structural stalls.
module fwd_hazard_unit #(
  parameter int NUM_SRC = 2,
  parameter int AW      = 5,
  parameter int MDU_LAT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hold,
  input  logic [NUM_SRC*AW-1:0]  id_src,
  input  logic [NUM_SRC-1:0]     id_src_used,
  input  logic                   id_mdu_start,
  input  logic [AW-1:0]          ex_dst,
  input  logic                   ex_regwrite,
  input  logic                   ex_memtoreg,
  input  logic                   ex_mdu_start,
  input  logic [AW-1:0]          mem_dst,
  input  logic                   mem_regwrite,
  output logic [2*NUM_SRC-1:0]   fwd_sel_ex,
  output logic                   stall,
  output logic                   mdu_busy
);

  localparam int CW = $clog2(MDU_LAT + 1);

  typedef enum logic {IDLE, BUSY} mduState_t;

  mduState_t           state, stateNext;
  logic [CW-1:0]       cnt, cntNext;
  logic [AW-1:0]       mduDst, mduDstNext;
  logic [NUM_SRC-1:0]  hit;
  logic [2*NUM_SRC-1:0] fwdSelId;
  logic                loadUse, mduRaw, mduStruct;

  assign mdu_busy = (state == BUSY);

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_SRC; i++)
      hit[i] = id_src_used[i] && (id_src[i*AW +: AW] != '0);
  end

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    fwdSelId = '0;
    loadUse  = 1'b0;
    mduRaw   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      // Nearest producer (EX, which will be in MEM) takes priority over MEM.
      if (hit[i] && ex_regwrite && ex_dst == id_src[i*AW +: AW])
        fwdSelId[2*i +: 2] = 2'b10;
      else if (hit[i] && mem_regwrite && mem_dst == id_src[i*AW +: AW])
        fwdSelId[2*i +: 2] = 2'b01;
      if (hit[i] && ex_regwrite && ex_memtoreg && ex_dst == id_src[i*AW +: AW])
        loadUse = 1'b1;
      if (hit[i] && mdu_busy && mduDst == id_src[i*AW +: AW])
        mduRaw = 1'b1;
    end
  end

  assign mduStruct = id_mdu_start && mdu_busy && (cnt > CW'(1));
  assign stall     = (loadUse || mduRaw || mduStruct) && !hold;

  // The MDU scoreboard runs independently of hold: the unit keeps computing.
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    mduDstNext = mduDst;
    case (state)
      IDLE: begin
        if (ex_mdu_start) begin
          stateNext  = BUSY;
          cntNext    = CW'(MDU_LAT - 1);
          mduDstNext = ex_dst;
        end
      end
      BUSY: begin
        if (cnt <= CW'(1)) begin
          if (ex_mdu_start) begin
            cntNext    = CW'(MDU_LAT - 1);
            mduDstNext = ex_dst;
          end else begin
            stateNext = IDLE;
            cntNext   = '0;
          end
        end else begin
          cntNext = cnt - CW'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      mduDst     <= '0;
      fwd_sel_ex <= '0;
    end else begin
      state  <= stateNext;
      cnt    <= cntNext;
      mduDst <= mduDstNext;
      if (!hold)
        fwd_sel_ex <= stall ? '0 : fwdSelId;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed self-checking bench for fwd_hazard_unit (NUM_SRC=2, AW=5, MDU_LAT=4).
module tb_fwd_hazard_unit;

  localparam int NUM_SRC = 2;
  localparam int AW      = 5;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  hold;
  logic [NUM_SRC*AW-1:0] id_src;
  logic [NUM_SRC-1:0]    id_src_used;
  logic                  id_mdu_start;
  logic [AW-1:0]         ex_dst;
  logic                  ex_regwrite;
  logic                  ex_memtoreg;
  logic                  ex_mdu_start;
  logic [AW-1:0]         mem_dst;
  logic                  mem_regwrite;
  logic [2*NUM_SRC-1:0]  fwd_sel_ex;
  logic                  stall;
  logic                  mdu_busy;

  int checkCount = 0;
  int errorCount = 0;

  fwd_hazard_unit #(.NUM_SRC(NUM_SRC), .AW(AW), .MDU_LAT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .hold         (hold),
    .id_src       (id_src),
    .id_src_used  (id_src_used),
    .id_mdu_start (id_mdu_start),
    .ex_dst       (ex_dst),
    .ex_regwrite  (ex_regwrite),
    .ex_memtoreg  (ex_memtoreg),
    .ex_mdu_start (ex_mdu_start),
    .mem_dst      (mem_dst),
    .mem_regwrite (mem_regwrite),
    .fwd_sel_ex   (fwd_sel_ex),
    .stall        (stall),
    .mdu_busy     (mdu_busy)
  );

  always #5 clk = ~clk;

  // A new MDU op may only enter EX when the MDU is idle or on its last cycle.
  always @(negedge clk) begin
    if (!rst && ex_mdu_start && mdu_busy)
      assert (dut.cnt <= 1) else $error("protocol: MDU start while counter=%0d", dut.cnt);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    hold = 0; id_src = '0; id_src_used = '0; id_mdu_start = 0;
    ex_dst = '0; ex_regwrite = 0; ex_memtoreg = 0; ex_mdu_start = 0;
    mem_dst = '0; mem_regwrite = 0;
  endtask

  task automatic setSrc(input logic [AW-1:0] s1, input logic [AW-1:0] s0, input logic [1:0] used);
    id_src = {s1, s0};
    id_src_used = used;
  endtask

  initial begin
    clearInputs();
    rst = 1;
    #1;
    check("reset_fwd", 32'(fwd_sel_ex), 32'h0);
    check("reset_busy", 32'(mdu_busy), 32'h0);
    check("reset_stall", 32'(stall), 32'h0);
    repeat (2) step();
    rst = 0;

    // Forwarding priority: EX beats MEM, then MEM alone, r0 never forwards.
    setSrc(5'd0, 5'd5, 2'b11);
    ex_dst = 5; ex_regwrite = 1; mem_dst = 5; mem_regwrite = 1;
    #1 check("fwd_noload_stall", 32'(stall), 32'h0);
    step();
    check("fwd_ex_wins", 32'(fwd_sel_ex), 32'b0010);
    ex_regwrite = 0;
    step();
    check("fwd_mem", 32'(fwd_sel_ex), 32'b0001);
    setSrc(5'd0, 5'd3, 2'b11);
    ex_dst = 0; ex_regwrite = 1; mem_regwrite = 0;
    step();
    check("fwd_r0", 32'(fwd_sel_ex), 32'b0000);

    // Unused source: no stall and no select even with a matching load in EX.
    setSrc(5'd6, 5'd5, 2'b10);
    ex_dst = 5; ex_regwrite = 1; ex_memtoreg = 1; mem_dst = 6; mem_regwrite = 1;
    #1 check("unused_nostall", 32'(stall), 32'h0);
    step();
    check("unused_sel", 32'(fwd_sel_ex), 32'b0100);

    // Load-use: one-cycle stall with bubble, then WB forwarding.
    clearInputs();
    setSrc(5'd7, 5'd0, 2'b10);
    ex_dst = 7; ex_regwrite = 1; ex_memtoreg = 1;
    #1 check("lu_stall", 32'(stall), 32'h1);
    step();
    check("lu_bubble", 32'(fwd_sel_ex), 32'h0);
    ex_dst = 0; ex_regwrite = 0; ex_memtoreg = 0; mem_dst = 7; mem_regwrite = 1;
    #1 check("lu_release", 32'(stall), 32'h0);
    step();
    check("lu_sel_wb", 32'(fwd_sel_ex), 32'b0100);

    // MDU RAW: busy for 3 cycles, dependent stalls, then released with 01.
    clearInputs();
    ex_mdu_start = 1; ex_dst = 9;
    setSrc(5'd0, 5'd9, 2'b01);
    step();
    ex_mdu_start = 0; ex_dst = 0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("mdu_busy_c%0d", i), 32'(mdu_busy), 32'h1);
      check($sformatf("mdu_raw_c%0d", i), 32'(stall), 32'h1);
      step();
      check($sformatf("mdu_bubble_c%0d", i), 32'(fwd_sel_ex), 32'h0);
    end
    check("mdu_done", 32'(mdu_busy), 32'h0);
    mem_dst = 9; mem_regwrite = 1;
    #1 check("mdu_released", 32'(stall), 32'h0);
    step();
    check("mdu_sel_wb", 32'(fwd_sel_ex), 32'b0001);

    // Structural stall and back-to-back reload.
    clearInputs();
    ex_mdu_start = 1; ex_dst = 10;
    step();
    ex_mdu_start = 0; ex_dst = 0; id_mdu_start = 1;
    #1 check("struct_cnt3", 32'(stall), 32'h1);
    step();
    check("struct_cnt2", 32'(stall), 32'h1);
    step();
    check("struct_cnt1", 32'(stall), 32'h0);
    ex_mdu_start = 1; ex_dst = 11;
    step();
    ex_mdu_start = 0; ex_dst = 0; id_mdu_start = 0;
    check("b2b_busy", 32'(mdu_busy), 32'h1);
    setSrc(5'd0, 5'd10, 2'b01);
    #1 check("b2b_old_dst", 32'(stall), 32'h0);
    setSrc(5'd0, 5'd11, 2'b01);
    #1 check("b2b_new_dst", 32'(stall), 32'h1);
    setSrc(5'd0, 5'd0, 2'b00);
    step();
    step();
    check("b2b_last", 32'(mdu_busy), 32'h1);
    step();
    check("b2b_idle", 32'(mdu_busy), 32'h0);

    // Hold: selects frozen, stall masked, MDU counter still expires.
    clearInputs();
    setSrc(5'd0, 5'd5, 2'b01);
    mem_dst = 5; mem_regwrite = 1;
    step();
    check("hold_pre", 32'(fwd_sel_ex), 32'b0001);
    ex_mdu_start = 1; ex_dst = 12;
    step();
    ex_mdu_start = 0; hold = 1; mem_regwrite = 0;
    setSrc(5'd0, 5'd12, 2'b01);
    ex_dst = 12; ex_regwrite = 1;
    #1 check("hold_nostall", 32'(stall), 32'h0);
    step();
    step();
    check("hold_busy_cnt1", 32'(mdu_busy), 32'h1);
    step();
    check("hold_expired", 32'(mdu_busy), 32'h0);
    check("hold_frozen", 32'(fwd_sel_ex), 32'b0001);
    hold = 0;
    step();
    check("hold_released", 32'(fwd_sel_ex), 32'b0010);

    // Combined hazards, then reset mid-BUSY.
    clearInputs();
    setSrc(5'd0, 5'd5, 2'b01);
    mem_dst = 5; mem_regwrite = 1;
    ex_mdu_start = 1; ex_dst = 13;
    step();
    check("rst_pre_fwd", 32'(fwd_sel_ex), 32'b0001);
    ex_mdu_start = 0; mem_regwrite = 0;
    setSrc(5'd7, 5'd13, 2'b11);
    ex_dst = 7; ex_regwrite = 1; ex_memtoreg = 1;
    #1 check("both_stall", 32'(stall), 32'h1);
    ex_regwrite = 0; ex_memtoreg = 0; ex_dst = 0;
    #1 check("mdu_only_stall", 32'(stall), 32'h1);
    #1 rst = 1;
    #1;
    check("rst_async_busy", 32'(mdu_busy), 32'h0);
    check("rst_async_fwd", 32'(fwd_sel_ex), 32'h0);
    check("rst_nostall", 32'(stall), 32'h0);
    #1 rst = 0;
    step();
    check("rst_stays_idle", 32'(mdu_busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Next-generation forwarding/hazard unit for the 5-stage pipeline.
- Computes bypass selects in ID and registers them into EX, which takes the compare logic off the EX critical path.
- Generalised to NUM_SRC read ports.
- Adds load-use stall detection and a multi-cycle MDU scoreboard with RAW and structural stalls.

Parameters:
- NUM_SRC, 2, number of register source operands per instruction.
- AW, 5, register address width; address 0 is hardwired zero.
- MDU_LAT, 4, cycles from MDU start in EX to MDU result write in WB (minimum 2).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- hold  in  1  external pipeline freeze (cache miss); all state except the MDU counter holds.
- id_src  in  NUM_SRC*AW  ID-stage source regs; port i occupies bits [i*AW +: AW].
- id_src_used  in  NUM_SRC  per-source "operand actually read" flag.
- id_mdu_start  in  1  ID instruction is an MDU op.
- ex_dst  in  AW  EX-stage destination.
- ex_regwrite  in  1  EX-stage register write enable.
- ex_memtoreg  in  1  EX-stage instruction is a load.
- ex_mdu_start  in  1  MDU op issuing in EX this cycle.
- mem_dst  in  AW  MEM-stage destination.
- mem_regwrite  in  1  MEM-stage register write enable.
- fwd_sel_ex  out  2*NUM_SRC  registered bypass select for the EX operand muxes, 2 bits per source: 00 regfile, 10 MEM result, 01 WB result.
- stall  out  1  combinational; freezes IF/ID and inserts a bubble into EX.
- mdu_busy  out  1  registered; MDU result pending.

Behaviour:
- Reset (async, immediate): fwd_sel_ex=0, mdu_busy=0, MDU counter=0, mdu_dst=0.
- Select computation (combinational, ID), per source i, with hit = id_src_used[i] and id_src[i]!=0:
  - hit and ex_regwrite and ex_dst==id_src[i]: 10. The producer will be in MEM when the consumer reaches EX.
  - else hit and mem_regwrite and mem_dst==id_src[i]: 01. The producer will be in WB.
  - else 00.
  - Nearest producer wins.
- Load-use: load_use = OR over i of (hit and ex_regwrite and ex_memtoreg and ex_dst==id_src[i]).
- MDU RAW: mdu_raw = OR over i of (hit and mdu_busy and mdu_dst==id_src[i]).
- MDU structural: mdu_struct = id_mdu_start and mdu_busy and (counter>1).
- stall = (load_use or mdu_raw or mdu_struct) and not hold.
- fwd_sel_ex register, on each posedge:
  - hold: keep value.
  - stall: load 0 (bubble).
  - otherwise: load the computed selects.
- Load-use recovery: after a one-cycle load-use stall the same ID instruction recomputes. The load is now in MEM, so the select becomes 01, and data is taken from WB when the consumer is in EX.
- MDU scoreboard FSM:
  - IDLE (mdu_busy=0): on ex_mdu_start, set counter=MDU_LAT-1, latch mdu_dst=ex_dst, go to BUSY. ex_dst==0 still occupies the MDU.
  - BUSY: counter decrements every cycle, regardless of hold.
  - Counter reaches 1 and ex_mdu_start is asserted the same cycle: reload counter and mdu_dst; remain BUSY (back-to-back issue).
  - Counter reaches 1 and no ex_mdu_start: go to IDLE, mdu_busy=0.
  - Once counter==1, the result is in WB the following cycle; a dependent instruction is released and receives it via the normal 01 path.
  - ex_mdu_start while counter>1 is a protocol violation (it is prevented by stall); the bench flags it with an assertion.
- Simultaneous events: load_use and mdu_raw together produce a single stall; the stall persists until both clear.
- Reset mid-MDU: returns to IDLE at once; the pending result is discarded.
- No stall, and no select change, for sources with id_src_used=0.

Test Plan:
- EX writes r5 and MEM writes r5; ID src0=r5 -> next cycle fwd_sel_ex[1:0]=10. Remove the EX write -> 01. src1=r0 with EX writing r0 -> 00.
- EX load r7, ID src1=r7 -> stall=1 for exactly one cycle and fwd_sel_ex=0 (bubble). The following cycle, with r7 now in MEM -> stall=0, fwd_sel_ex[3:2]=01.
- MDU_LAT=4, ex_mdu_start with ex_dst=r9 -> mdu_busy 1 for 3 cycles. ID src0=r9 stalls for those cycles and then releases with select 01.
- MDU busy with counter=3, id_mdu_start=1 -> stall held until the counter reaches 1. The back-to-back start reloads the counter and mdu_busy never drops.
- hold=1 during an MDU op -> fwd_sel_ex frozen and stall=0, while the counter still expires on schedule.
- Assert rst mid-BUSY -> mdu_busy and fwd_sel_ex are 0 without waiting for a clock edge, and a dependent ID instruction does not stall.
